// File: rtl/fir_pkg.sv
// Shared constants and FSM state type for the FIR sample feeder.
package fir_pkg;
  localparam int SAMPLE_W        = 8;
  localparam int DEF_DEPTH       = 8;
  localparam int DEF_MIN_GAP     = 8;
  localparam int DEF_ACK_TIMEOUT = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } fsm_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pointers wrap modulo DEPTH (power of two).
module sync_fifo
  import fir_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  // Storage needs no reset; the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/fir_sample_feeder.sv
// Buffers upstream samples and hands them one at a time to the FIR filter
// using a flag/done handshake with a minimum pulse spacing and ack timeout.
//
// state        | meaning
// ST_IDLE      | waiting for a sample, done_flag high and gap expired; pops on exit
// ST_ISSUE     | sample latched in data; flag register loads for next cycle
// ST_WAIT_ACK  | waiting for done_flag to fall, bounded by ACK_TIMEOUT
// ST_WAIT_DONE | filter busy; waiting for done_flag to rise again
module fir_sample_feeder
  import fir_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int MIN_GAP     = DEF_MIN_GAP,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [SAMPLE_W-1:0]  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [SAMPLE_W-1:0]  data,
  output logic                        input_data_flag,
  input  logic                        done_flag,
  output logic [$clog2(DEPTH):0]      fifo_count,
  output logic                        overflow,
  output logic                        ack_err
);
  localparam int GAP_W = $clog2(MIN_GAP);
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

  fsm_state_e                  state_q, state_d;
  logic [GAP_W-1:0]            gap_q, gap_d;
  logic [TO_W-1:0]             to_q, to_d;
  logic signed [SAMPLE_W-1:0]  data_q, data_d;
  logic                        flag_q, flag_d;
  logic                        ovf_q, ovf_d;
  logic                        ackerr_q, ackerr_d;

  logic                        push, pop;
  logic                        fifo_full, fifo_empty;
  logic [SAMPLE_W-1:0]         fifo_rdata;

  assign in_ready        = !fifo_full;
  assign push            = in_valid && in_ready;
  assign data            = data_q;
  assign input_data_flag = flag_q;
  assign overflow        = ovf_q;
  assign ack_err         = ackerr_q;

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ($unsigned(in_data)),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    gap_d    = (gap_q != '0) ? gap_q - GAP_W'(1) : '0;
    to_d     = to_q;
    data_d   = data_q;
    flag_d   = (state_q == ST_ISSUE);
    ovf_d    = ovf_q | (in_valid & ~in_ready);
    ackerr_d = ackerr_q;
    pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && done_flag && gap_q == '0) begin
          pop     = 1'b1;
          data_d  = $signed(fifo_rdata);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        gap_d   = GAP_W'(MIN_GAP - 1);
        to_d    = TO_W'(ACK_TIMEOUT - 1);
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (!done_flag) begin
          state_d = ST_WAIT_DONE;
        end else if (to_q == '0) begin
          ackerr_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          to_d = to_q - TO_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (done_flag) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gap_q    <= '0;
      to_q     <= '0;
      data_q   <= '0;
      flag_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ackerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      to_q     <= to_d;
      data_q   <= data_d;
      flag_q   <= flag_d;
      ovf_q    <= ovf_d;
      ackerr_q <= ackerr_d;
    end
  end
endmodule

// File: tb/tb_fir_sample_feeder.sv
// Scenario bench for fir_sample_feeder: directed handshake cases plus a
// randomized run scored against an in-order queue model of the feeder.
module tb_fir_sample_feeder;
  localparam int DEPTH       = 8;
  localparam int MIN_GAP     = 8;
  localparam int ACK_TIMEOUT = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic signed [7:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [7:0] data;
  logic              input_data_flag;
  logic              done_flag = 1'b1;
  logic [3:0]        fifo_count;
  logic              overflow;
  logic              ack_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit auto_filt = 1'b0;
  int filt_t = -1;
  logic signed [7:0] got_q[$];
  int                pcyc_q[$];

  fir_sample_feeder #(
    .DEPTH       (DEPTH),
    .MIN_GAP     (MIN_GAP),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .data            (data),
    .input_data_flag (input_data_flag),
    .done_flag       (done_flag),
    .fifo_count      (fifo_count),
    .overflow        (overflow),
    .ack_err         (ack_err)
  );

  always #5 clk = ~clk;

  // One clock edge; sample 1ns later, log pulses and advance the filter model
  // (done falls one cycle after the flag, rises six cycles after that).
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (input_data_flag === 1'b1) begin
      got_q.push_back(data);
      pcyc_q.push_back(cyc);
    end
    if (auto_filt) begin
      if (input_data_flag === 1'b1) filt_t = 0;
      else if (filt_t >= 0) filt_t++;
      if (filt_t == 1) done_flag = 1'b0;
      if (filt_t == 7) begin
        done_flag = 1'b1;
        filt_t = -1;
      end
    end
  endtask

  task automatic do_reset();
    auto_filt = 1'b0;
    filt_t = -1;
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got_q.delete();
    pcyc_q.delete();
  endtask

  task automatic push_one(input logic signed [7:0] v);
    in_data = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (fifo_count !== 4'd0) begin n_bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
    n_cmp++; if (input_data_flag !== 1'b0) begin n_bad++; $display("FAIL reset_flag got=%b want=0", input_data_flag); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    n_cmp++; if (ack_err !== 1'b0) begin n_bad++; $display("FAIL reset_ack_err got=%b want=0", ack_err); end
  endtask

  task automatic test_min_latency();
    do_reset();
    done_flag = 1'b1;
    push_one(8'sd5);
    n_cmp++; if (input_data_flag !== 1'b0) begin n_bad++; $display("FAIL lat_edge0_flag got=%b want=0", input_data_flag); end
    tick();
    n_cmp++; if (input_data_flag !== 1'b0) begin n_bad++; $display("FAIL lat_edge1_flag got=%b want=0", input_data_flag); end
    tick();
    n_cmp++; if (input_data_flag !== 1'b1) begin n_bad++; $display("FAIL lat_edge2_flag got=%b want=1", input_data_flag); end
    n_cmp++; if (data !== 8'sd5) begin n_bad++; $display("FAIL lat_data got=%0d want=5", data); end
    tick();
    n_cmp++; if (input_data_flag !== 1'b0) begin n_bad++; $display("FAIL lat_edge3_flag got=%b want=0", input_data_flag); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit order_ok;
    bit gap_ok;
    do_reset();
    done_flag = 1'b1;
    auto_filt = 1'b1;
    push_one(8'sd1);
    push_one(8'sd2);
    push_one(8'sd3);
    wait_pulses(3, 200, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_pulses got=%0d want=3", got_q.size()); end
    order_ok = (got_q.size() == 3);
    gap_ok = 1'b1;
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      if (got_q[i] !== 8'(i + 1)) order_ok = 1'b0;
      if (i > 0 && pcyc_q[i] - pcyc_q[i-1] < MIN_GAP) gap_ok = 1'b0;
    end
    n_cmp++; if (!order_ok) begin n_bad++; $display("FAIL b2b_order got_n=%0d want=1,2,3", got_q.size()); end
    n_cmp++; if (!gap_ok) begin n_bad++; $display("FAIL b2b_spacing got<%0d want>=%0d", MIN_GAP, MIN_GAP); end
  endtask

  task automatic test_overflow();
    logic signed [7:0] exp_q[$];
    logic signed [7:0] v;
    bit ok;
    bit match;
    do_reset();
    done_flag = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      v = 8'($urandom);
      exp_q.push_back(v);
      push_one(v);
    end
    n_cmp++; if (fifo_count !== 4'(DEPTH)) begin n_bad++; $display("FAIL ovf_full_count got=%0d want=%0d", fifo_count, DEPTH); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL ovf_in_ready got=%b want=0", in_ready); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_early got=%b want=0", overflow); end
    push_one(8'sh7f);
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
    n_cmp++; if (fifo_count !== 4'(DEPTH)) begin n_bad++; $display("FAIL ovf_count got=%0d want=%0d", fifo_count, DEPTH); end
    done_flag = 1'b1;
    auto_filt = 1'b1;
    wait_pulses(DEPTH, 300, ok);
    repeat (20) tick();
    match = (got_q.size() == DEPTH);
    for (int i = 0; i < got_q.size() && i < DEPTH; i++)
      if (got_q[i] !== exp_q[i]) match = 1'b0;
    n_cmp++; if (!ok || !match) begin n_bad++; $display("FAIL ovf_drain got_n=%0d want_n=%0d", got_q.size(), DEPTH); end
  endtask

  task automatic test_ack_timeout();
    logic signed [7:0] a;
    logic signed [7:0] b;
    bit early;
    a = 8'sd17;
    b = -8'sd42;
    do_reset();
    done_flag = 1'b1;
    push_one(a);
    push_one(b);
    tick();
    n_cmp++; if (input_data_flag !== 1'b1 || data !== a) begin n_bad++; $display("FAIL to_first_pulse got=%b/%0d want=1/%0d", input_data_flag, data, a); end
    tick();
    tick();
    n_cmp++; if (ack_err !== 1'b0) begin n_bad++; $display("FAIL to_early got=%b want=0", ack_err); end
    tick();
    n_cmp++; if (ack_err !== 1'b1) begin n_bad++; $display("FAIL to_ack_err got=%b want=1", ack_err); end
    early = 1'b0;
    for (int e = 6; e <= 10; e++) begin
      tick();
      if (input_data_flag !== 1'b0) early = 1'b1;
    end
    n_cmp++; if (early) begin n_bad++; $display("FAIL to_gap got=pulse want=none_before_edge11"); end
    tick();
    n_cmp++; if (input_data_flag !== 1'b1 || data !== b) begin n_bad++; $display("FAIL to_next_pulse got=%b/%0d want=1/%0d", input_data_flag, data, b); end
    n_cmp++; if (ack_err !== 1'b1) begin n_bad++; $display("FAIL to_sticky got=%b want=1", ack_err); end
  endtask

  task automatic test_reset_in_issue();
    logic signed [7:0] exp_q[$];
    logic signed [7:0] v;
    do_reset();
    done_flag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v = 8'($urandom_range(1, 100));
      exp_q.push_back(v);
      push_one(v);
    end
    done_flag = 1'b1;
    tick();
    n_cmp++; if (data !== exp_q[0]) begin n_bad++; $display("FAIL rst_issue_data got=%0d want=%0d", data, exp_q[0]); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (input_data_flag !== 1'b0) begin n_bad++; $display("FAIL rst_issue_flag got=%b want=0", input_data_flag); end
    n_cmp++; if (fifo_count !== 4'd0) begin n_bad++; $display("FAIL rst_issue_count got=%0d want=0", fifo_count); end
    n_cmp++; if (data !== 8'sd0) begin n_bad++; $display("FAIL rst_issue_data0 got=%0d want=0", data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_issue_ready got=%b want=1", in_ready); end
    got_q.delete();
    repeat (30) tick();
    n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL rst_issue_quiet got=%0d want=0", got_q.size()); end
  endtask

  task automatic test_wrap_simul();
    logic signed [7:0] exp_q[$];
    logic signed [7:0] v;
    bit ok;
    bit match;
    do_reset();
    done_flag = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      v = 8'($urandom);
      exp_q.push_back(v);
      push_one(v);
    end
    n_cmp++; if (fifo_count !== 4'(DEPTH - 1)) begin n_bad++; $display("FAIL wrap_pre_count got=%0d want=%0d", fifo_count, DEPTH - 1); end
    done_flag = 1'b1;
    v = 8'($urandom);
    exp_q.push_back(v);
    push_one(v);
    n_cmp++; if (fifo_count !== 4'(DEPTH - 1)) begin n_bad++; $display("FAIL wrap_simul_count got=%0d want=%0d", fifo_count, DEPTH - 1); end
    n_cmp++; if (data !== exp_q[0]) begin n_bad++; $display("FAIL wrap_pop_data got=%0d want=%0d", data, exp_q[0]); end
    auto_filt = 1'b1;
    v = 8'($urandom);
    exp_q.push_back(v);
    push_one(v);
    wait_pulses(exp_q.size(), 400, ok);
    match = (got_q.size() == exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) match = 1'b0;
    n_cmp++; if (!ok || !match) begin n_bad++; $display("FAIL wrap_order got_n=%0d want_n=%0d", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_random();
    logic signed [7:0] exp_q[$];
    bit exp_ovf;
    bit ok;
    bit match;
    bit gap_ok;
    int first_bad;
    do_reset();
    done_flag = 1'b1;
    auto_filt = 1'b1;
    exp_ovf = 1'b0;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      in_data = 8'($urandom);
      if (in_valid && in_ready === 1'b1) exp_q.push_back(in_data);
      if (in_valid && in_ready === 1'b0) exp_ovf = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    wait_pulses(exp_q.size(), 400, ok);
    match = ok && (got_q.size() == exp_q.size());
    first_bad = -1;
    gap_ok = 1'b1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i] && first_bad < 0) begin
        first_bad = i;
        match = 1'b0;
      end
      if (i > 0 && pcyc_q[i] - pcyc_q[i-1] < MIN_GAP) gap_ok = 1'b0;
    end
    n_cmp++; if (!match) begin n_bad++; $display("FAIL rnd_stream got_n=%0d want_n=%0d first_bad_idx=%0d", got_q.size(), exp_q.size(), first_bad); end
    n_cmp++; if (!gap_ok) begin n_bad++; $display("FAIL rnd_spacing got<%0d want>=%0d", MIN_GAP, MIN_GAP); end
    n_cmp++; if (overflow !== exp_ovf) begin n_bad++; $display("FAIL rnd_overflow got=%b want=%b", overflow, exp_ovf); end
    n_cmp++; if (ack_err !== 1'b0) begin n_bad++; $display("FAIL rnd_ack_err got=%b want=0", ack_err); end
  endtask

  initial begin
    test_reset();
    test_min_latency();
    test_back_to_back();
    test_overflow();
    test_ack_timeout();
    test_reset_in_issue();
    test_wrap_simul();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
